// File: rtl/ntt_pkg.sv
// Shared constants and helpers for the NTT / polynomial datapath.
package ntt_pkg;

    localparam int unsigned KYBER_Q     = 3329;
    localparam int unsigned DILITHIUM_Q = 8380417;

    // Default lane / width configuration of the reducer.
    localparam int unsigned DEF_QW    = 16;
    localparam int unsigned DEF_CW    = 32;
    localparam int unsigned DEF_K     = 32;
    localparam int unsigned DEF_LANES = 4;
    localparam int unsigned DEF_TAGW  = 8;

    // Barrett constant floor(2^k / q), evaluated at elaboration time.
    function automatic logic [63:0] barrett_mu(input int unsigned q, input int unsigned k);
        return (64'd1 << k) / 64'(q);
    endfunction

endpackage

// File: rtl/barrett_lane.sv
// One reduction lane: S1 quotient estimate, S2 remainder, S3 final corrections.
module barrett_lane
    import ntt_pkg::*;
#(
    parameter int unsigned Q  = KYBER_Q,
    parameter int unsigned QW = DEF_QW,
    parameter int unsigned CW = DEF_CW,
    parameter int unsigned K  = DEF_K
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    ld,      // per-stage load enable, shared by all lanes
    input  logic [CW-1:0] c,
    output logic [QW-1:0] res
);

    localparam int unsigned PW = CW + K + 1;
    localparam int unsigned RW = QW + 2;
    localparam logic [PW-1:0] MU_P = PW'(barrett_mu(Q, K));
    localparam logic [RW-1:0] Q_R  = RW'(Q);

    logic [CW:0]   qhat_s1;
    logic [CW-1:0] c_s1;
    logic [RW-1:0] r_s2;

    logic [CW:0]   qhat_c;
    logic [CW-1:0] qq_c;
    logic [RW-1:0] r_c;
    logic [RW-1:0] t1_c;
    logic [RW-1:0] t2_c;

    // Quotient estimate and remainder arithmetic; the remainder is exact
    // modulo 2^RW, and its true value is small, so the truncation is lossless.
    always_comb begin
        qhat_c = (CW + 1)'((PW'(c) * MU_P) >> K);
        qq_c   = CW'(qhat_s1) * CW'(Q);
        r_c    = RW'(c_s1 - qq_c);
        t1_c   = (r_s2 >= Q_R) ? r_s2 - Q_R : r_s2;
        t2_c   = (t1_c >= Q_R) ? t1_c - Q_R : t1_c;
    end

    // Stage registers; each stage only loads when a valid vector enters it,
    // so the output holds its last value across bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qhat_s1 <= '0;
            c_s1    <= '0;
            r_s2    <= '0;
            res     <= '0;
        end else begin
            if (ld[0]) begin
                qhat_s1 <= qhat_c;
                c_s1    <= c;
            end
            if (ld[1]) r_s2 <= r_c;
            if (ld[2]) res  <= QW'(t2_c);
        end
    end

endmodule

// File: rtl/barrett_reduce_pipe.sv
// Multi-lane pipelined Barrett reducer with valid/ready and backpressure.
module barrett_reduce_pipe
    import ntt_pkg::*;
#(
    parameter int unsigned Q     = KYBER_Q,
    parameter int unsigned QW    = DEF_QW,
    parameter int unsigned CW    = DEF_CW,
    parameter int unsigned K     = DEF_K,
    parameter int unsigned LANES = DEF_LANES,
    parameter int unsigned TAGW  = DEF_TAGW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*CW-1:0]   in_data,
    input  logic [TAGW-1:0]       in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*QW-1:0]   out_data,
    output logic [TAGW-1:0]       out_tag
);

    localparam int unsigned STAGES = 3;

    logic                        stall;
    logic                        vld_in;
    logic [STAGES:1]             vld_pipe;
    logic [STAGES:1][TAGW-1:0]   tag_pipe;
    logic [2:0]                  ld;
    logic [LANES-1:0][CW-1:0]    c_vec;
    logic [LANES-1:0][QW-1:0]    res_vec;

    // Whole pipe freezes only when the output is held; bubbles drain freely.
    always_comb begin
        stall    = vld_pipe[STAGES] & ~out_ready;
        in_ready = ~stall;
        vld_in   = in_valid & in_ready;
        ld       = {~stall & vld_pipe[2], ~stall & vld_pipe[1], ~stall & vld_in};
        c_vec    = in_data;
        out_valid = vld_pipe[STAGES];
        out_tag   = tag_pipe[STAGES];
        out_data  = res_vec;
    end

    // Valid shift chain and tag sideband, advancing together when not stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else if (!stall) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], vld_in};
            if (vld_in) tag_pipe[1] <= in_tag;
            for (int s = 2; s <= STAGES; s++)
                if (vld_pipe[s-1]) tag_pipe[s] <= tag_pipe[s-1];
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        barrett_lane #(
            .Q  (Q),
            .QW (QW),
            .CW (CW),
            .K  (K)
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .ld  (ld),
            .c   (c_vec[i]),
            .res (res_vec[i])
        );
    end

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Scoreboard bench: two reducers (Q=3329 and Q=7681) share stimulus; each
// output is checked against plain c mod Q, tag, and latency where stall-free.
module tb_barrett_reduce_pipe;

    localparam int LANES = 4;
    localparam int CW    = 32;
    localparam int QW    = 16;
    localparam int TAGW  = 8;
    localparam int Q1    = 3329;
    localparam int Q2    = 7681;

    typedef logic [LANES-1:0][CW-1:0] vin_t;
    typedef logic [LANES-1:0][QW-1:0] vout_t;

    typedef struct {
        vout_t           e;
        logic [TAGW-1:0] tag;
        int              acc;
        bit              lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, out_ready;
    logic in_ready1, in_ready2, out_valid1, out_valid2;
    vin_t in_data;
    logic [TAGW-1:0] in_tag;
    logic [LANES*QW-1:0] out_data1, out_data2;
    logic [TAGW-1:0] out_tag1, out_tag2;

    exp_t sb1[$];
    exp_t sb2[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    barrett_reduce_pipe #(.Q(Q1), .QW(QW), .CW(CW), .K(32), .LANES(LANES), .TAGW(TAGW)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid1),
        .out_ready(out_ready), .out_data(out_data1), .out_tag(out_tag1));

    barrett_reduce_pipe #(.Q(Q2), .QW(QW), .CW(CW), .K(32), .LANES(LANES), .TAGW(TAGW)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid2),
        .out_ready(out_ready), .out_data(out_data2), .out_tag(out_tag2));

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vout_t ref_mod(input vin_t d, input int q);
        vout_t r;
        for (int i = 0; i < LANES; i++) begin
            longint unsigned c = 64'(d[i]);
            r[i] = QW'(c % longint'(q));
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] rnd_c();
        case ($urandom_range(0, 9))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'(Q1 - 1);
            3: return 32'(Q1);
            4: return 32'(Q2 * $urandom_range(1, 500000));
            5: return 32'(2 * Q1 - 1);
            default: return $urandom;
        endcase
    endfunction

    function automatic vin_t rnd_vec();
        vin_t v;
        for (int i = 0; i < LANES; i++) v[i] = rnd_c();
        return v;
    endfunction

    task automatic push(input vin_t d, input logic [TAGW-1:0] t, input bit lat);
        exp_t e;
        e.tag = t; e.acc = cyc; e.lat = lat;
        e.e = ref_mod(d, Q1); sb1.push_back(e);
        e.e = ref_mod(d, Q2); sb2.push_back(e);
    endtask

    // One clock of stimulus; reports whether the vector was accepted.
    task automatic step(input bit v, input vin_t d, input logic [TAGW-1:0] t,
                        input bit ordy, input bit lat, output bit acc);
        @(posedge clk); #1;
        in_valid = v; in_data = d; in_tag = t; out_ready = ordy;
        @(negedge clk);
        acc = v && in_ready1;
        if (acc) push(d, t, lat);
    endtask

    task automatic drain();
        bit a;
        for (int k = 0; k < 200; k++) begin
            if (sb1.size() == 0 && sb2.size() == 0) break;
            step(1'b0, '0, '0, 1'b1, 1'b0, a);
        end
        chk("drain_sb1_empty", sb1.size(), 0);
        chk("drain_sb2_empty", sb2.size(), 0);
    endtask

    task automatic mon(input int id, input logic v, input logic irdy,
                       input logic [LANES*QW-1:0] d, input logic [TAGW-1:0] t);
        exp_t  e;
        vout_t dv;
        bit    empty;
        dv = d;
        chk($sformatf("dut%0d_in_ready", id), irdy, !(v && !out_ready));
        if (v && out_ready) begin
            empty = (id == 1) ? (sb1.size() == 0) : (sb2.size() == 0);
            if (empty) begin
                n_cmp++; n_bad++;
                $display("FAIL dut%0d_unexpected_output: got tag %0d expected no output", id, t);
            end else begin
                if (id == 1) e = sb1.pop_front(); else e = sb2.pop_front();
                for (int i = 0; i < LANES; i++)
                    chk($sformatf("dut%0d_lane%0d_tag%0d", id, i, e.tag), dv[i], e.e[i]);
                chk($sformatf("dut%0d_tag", id), t, e.tag);
                if (e.lat) chk($sformatf("dut%0d_latency_tag%0d", id, e.tag), cyc - e.acc, 3);
            end
        end
    endtask

    always @(negedge clk) if (!rst) mon(1, out_valid1, in_ready1, out_data1, out_tag1);
    always @(negedge clk) if (!rst) mon(2, out_valid2, in_ready2, out_data2, out_tag2);

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   a;
        vin_t d;
        int   sent;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0; in_tag = '0;
        #12;
        chk("rst_out_valid", out_valid1, 0);
        chk("rst_out_data", out_data1, 0);
        chk("rst_out_tag", out_tag1, 0);
        chk("rst_in_ready", in_ready1, 1);
        chk("rst_out_valid2", out_valid2, 0);
        @(posedge clk); #1; rst = 1'b0;

        // Directed vectors with latency checks.
        d = {32'd6658, 32'd3329, 32'd3328, 32'd0};
        step(1'b1, d, 8'hA5, 1'b1, 1'b1, a);
        drain();
        d = {4{32'hFFFF_FFFF}};
        step(1'b1, d, 8'h5A, 1'b1, 1'b1, a);
        d = {32'd12345, 32'd7681, 32'd7680, 32'd12345};
        step(1'b1, d, 8'h3C, 1'b1, 1'b1, a);
        drain();

        // Random traffic with random gaps and backpressure.
        sent = 0;
        while (sent < 2500) begin
            step($urandom_range(0, 3) != 0, rnd_vec(), TAGW'($urandom),
                 $urandom_range(0, 3) != 0, 1'b0, a);
            if (a) sent++;
        end
        drain();

        // 20 back-to-back vectors with the output held off for cycles 5..9.
        sent = 0;
        for (int k = 0; k < 100; k++) begin
            if (sent >= 20 && k > 9) break;
            step(sent < 20, rnd_vec(), TAGW'(sent), !(k >= 5 && k <= 9), 1'b0, a);
            if (a) sent++;
        end
        chk("stall_stream_sent", sent, 20);
        drain();

        // Alternating input gaps; bubbles must pass through at fixed latency.
        for (int k = 0; k < 16; k++)
            step(k % 2 == 0, rnd_vec(), TAGW'(100 + k), 1'b1, 1'b1, a);
        drain();

        // Reset with three vectors in flight.
        for (int k = 0; k < 3; k++)
            step(1'b1, rnd_vec(), TAGW'(200 + k), 1'b1, 1'b0, a);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid1, 0);
        chk("midrst_out_valid2", out_valid2, 0);
        chk("midrst_out_tag", out_tag1, 0);
        chk("midrst_out_data", out_data1, 0);
        sb1.delete(); sb2.delete();
        @(posedge clk); #1; rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, '0, '0, 1'b1, 1'b0, a);
            chk("post_rst_idle_valid", out_valid1, 0);
        end
        step(1'b1, rnd_vec(), 8'hEE, 1'b1, 1'b1, a);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
